// File: rtl/data_mem_bank_if.sv
// Request/response bus of the byte-addressable data memory.
// Handshake: a request transfers on a rising edge where req=1 and ready=1; the
// requester holds req and its fields until then. Every transfer gets exactly one
// rvalid strobe on the following edge, and rdata/err are valid only while rvalid=1.
interface data_mem_bank_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              clr;
  logic              ready;
  logic              busy;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;
  logic              err;

  modport master (
    output req, we, size, sign_ext, addr, wdata, clr,
    input  ready, busy, rvalid, rdata, err
  );

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, clr,
    output ready, busy, rvalid, rdata, err
  );
endinterface

// File: rtl/data_mem_bank.sv
// Byte-addressable data memory with byte/half/word/double lanes, extended loads,
// a one-cycle registered response and a self-clearing array after reset or clr.
module data_mem_bank #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  data_mem_bank_if.slave bus,
  output logic [0:0]  dbg_state
);

  localparam int L      = DATA_W / 8;
  localparam int LANE_W = $clog2(L);
  localparam int IDX_W  = $clog2(DEPTH);

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              ready_c;
  logic              busy_c;
  logic              clear_we;
  logic              accept;

  logic [DATA_W-1:0] mem [DEPTH];

  logic [IDX_W-1:0]  idx;
  logic [LANE_W-1:0] off;
  logic [2:0]        off3;
  logic              misalign;
  logic              out_of_range;
  logic              bad_size;
  logic              error;
  logic [3:0]        nbytes;
  logic [7:0]        mask8;
  logic [L-1:0]      be;
  logic [DATA_W-1:0] wshift;
  logic [DATA_W-1:0] rd_word;
  logic [DATA_W-1:0] sh;
  logic              fill;
  logic [DATA_W-1:0] ld;

  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  assign accept = bus.req & ready_c;

  // Clear/idle sequencing; an accepted request in the same cycle wins over clr.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ready_c  = 1'b0;
    busy_c   = 1'b0;
    clear_we = 1'b0;
    case (state_q)
      CLEAR: begin
        busy_c   = 1'b1;
        clear_we = 1'b1;
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      IDLE: begin
        ready_c = 1'b1;
        if (bus.clr && !bus.req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address decode and access checks.
  always_comb begin
    idx          = bus.addr[LANE_W +: IDX_W];
    off          = bus.addr[LANE_W-1:0];
    off3         = 3'(off);
    out_of_range = (bus.addr >> (LANE_W + IDX_W)) != '0;
    bad_size     = (bus.size == 2'b11) && (DATA_W == 32);
    misalign     = 1'b0;
    nbytes       = 4'd1;
    mask8        = 8'h01;
    case (bus.size)
      2'b01: begin
        misalign = off3[0];
        nbytes   = 4'd2;
        mask8    = 8'h03;
      end
      2'b10: begin
        misalign = |off3[1:0];
        nbytes   = 4'd4;
        mask8    = 8'h0F;
      end
      2'b11: begin
        misalign = |off3;
        nbytes   = 4'd8;
        mask8    = 8'hFF;
      end
      default: begin
        misalign = 1'b0;
        nbytes   = 4'd1;
        mask8    = 8'h01;
      end
    endcase
    error  = misalign | out_of_range | bad_size;
    be     = L'(mask8 << off);
    wshift = bus.wdata << {off, 3'b000};
  end

  // Load path: shift the addressed lanes down, then extend above the access width.
  always_comb begin
    rd_word = mem[idx];
    sh      = rd_word >> {off, 3'b000};
    case (bus.size)
      2'b00:   fill = bus.sign_ext & sh[7];
      2'b01:   fill = bus.sign_ext & sh[15];
      2'b10:   fill = bus.sign_ext & sh[31];
      default: fill = bus.sign_ext & sh[DATA_W-1];
    endcase
    ld = sh;
    for (int i = 0; i < DATA_W; i++) begin
      if (i >= 8 * int'(nbytes)) ld[i] = fill;
    end
  end

  // The array itself has no reset; the CLEAR walk zeroes it.
  always_ff @(posedge clk) begin
    if (clear_we) begin
      mem[cnt_q] <= '0;
    end else if (accept && bus.we && !error) begin
      for (int i = 0; i < L; i++) begin
        if (be[i]) mem[idx][8*i +: 8] <= wshift[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      rvalid_q <= accept;
      err_q    <= accept & error;
      rdata_q  <= (accept && !bus.we && !error) ? ld : '0;
    end
  end

  assign bus.ready  = ready_c;
  assign bus.busy   = busy_c;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign bus.err    = err_q;
  assign dbg_state  = state_q;

endmodule
